fft_bfly_addsub: RTL and testbench
==================================

Name: fft_bfly_addsub

Overview:
- Radix-2 butterfly add/subtract stage.
- Sits directly downstream of the twiddle complex multiplier (dsp_mult).
- Buffers the un-twiddled "A" sample in an alignment FIFO until the matching twiddled product "BW" arrives.
- Produces A+BW and A−BW, requantised to the 25-bit stage format, for the next FFT stage.

Parameters:
- DATA_W, 25: real/imag width of A and of the outputs.
- PROD_W, 44: real/imag width of the product input.
- TW_FRAC, 17: fractional bits of the twiddle (Q1.17); the product is aligned by this shift.
- FIFO_DEPTH, 8: A-sample alignment FIFO depth (power of 2, ≥2).
- SCALE, 1: 1 = divide butterfly outputs by 2 (rounded); 0 = no scaling.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous active-high reset.
- a_i  in  50  A sample, {re[24:0], im[24:0]}, two's complement.
- a_valid_i  in  1  a_i valid; push into the alignment FIFO.
- prod_i  in  88  BW product, {re[43:0], im[43:0]}, from the multiplier's butterfly_stage_o.
- prod_valid_i  in  1  prod_i valid; pops one A sample.
- sum_o  out  50  A+BW, {re, im}.
- diff_o  out  50  A−BW, {re, im}.
- data_valid_o  out  1  sum_o/diff_o valid.
- sat_o  out  1  sticky: any output component saturated.
- err_o  out  1  sticky: FIFO overflow or underflow.
- sat_cnt_o  out  16  saturation event count (see Optional Feature).

Behaviour:
- Reset (async, reset_i=1):
  - sum_o, diff_o, data_valid_o, sat_o, err_o, sat_cnt_o are all 0.
  - FIFO is emptied; pipeline valids are cleared.
  - Reset mid-operation discards all in-flight samples; no output valid is asserted until new inputs arrive.
- No backpressure; valid-only streaming.
- Alignment FIFO:
  - Push on a_valid_i; pop on prod_valid_i.
  - Empty FIFO with simultaneous push and pop: a_i bypasses directly to the datapath. The FIFO stays empty and no error is raised.
  - Full with push and no pop: a_i is dropped, err_o set, occupancy unchanged.
  - Full with push and pop: both occur, occupancy unchanged, no error.
  - Empty with pop and no push: underflow. A is treated as 0, err_o set, output still produced.
  - Pointers wrap modulo FIFO_DEPTH; full/empty are distinguished by an extra pointer bit.
- Pipeline, 2 cycles from prod_valid_i to data_valid_o:
  - Stage 1 (register): popped A and prod_i are captured.
    - p = (prod + 2^(TW_FRAC−1)) >>> TW_FRAC, per component, giving 27 bits signed.
    - s = A + p and d = A − p are computed at 28 bits signed (A sign-extended).
  - Stage 2 (register):
    - If SCALE=1: r = (x + 1) >>> 1. If SCALE=0: r = x.
    - r is saturated to DATA_W signed range [−2^24, 2^24−1].
    - Registered into sum_o/diff_o.
- Rounding is round-half-up (toward +inf on ties).
- Saturation:
  - Any of the 4 components clipping in a valid cycle sets sat_o (sticky until reset).
  - That cycle counts as one saturation event.
- Back-to-back prod_valid_i every cycle sustains 1 output per cycle.
- sum_o/diff_o hold their last value when data_valid_o=0.

Optional Feature:
- Macro: FFT_BFLY_SAT_CNT_EN.
- Defined:
  - sat_cnt_o is a 16-bit counter, incremented once per output cycle with any saturation.
  - Saturates at 0xFFFF (no wrap); reset to 0.
- Undefined:
  - sat_cnt_o is tied to 0 and no counter logic is generated.
  - sat_o is unaffected.

Test Plan:
- SCALE=1; a_i re=1000, im=−200; prod re=500·2^17, im=100·2^17; both valid same cycle (empty-FIFO bypass) → 2 cycles later data_valid_o=1, sum=(750,−50), diff=(250,−150), err_o=0.
- SCALE=0; push 3 A samples (re=1,2,3), then 3 products re=10·2^17 spaced 2 cycles apart → sums re=11,12,13 in order, diffs re=−9,−8,−7, no error.
- SCALE=0; A re=2^24−1, prod re=(2^24−1)·2^17 → sum re=16777215 (clipped), sat_o=1, sat_cnt_o=1 (macro on) or 0 (macro off).
- FIFO_DEPTH=8; push 9 A samples with no products → err_o=1 after the 9th; then 8 products return the first 8 samples in order.
- prod_valid_i with empty FIFO, no push, SCALE=0, prod re=4·2^17 → sum re=4, diff re=−4, err_o=1.
- Assert reset_i for 1 cycle while 2 samples are in flight → no data_valid_o afterwards; all outputs 0; next fresh pair processed normally.

Source files
------------

// File: rtl/fft_bfly_addsub.sv
// fft_bfly_addsub: radix-2 butterfly add/subtract with A-alignment FIFO, rounding and saturation.
// Optional saturation event counter enabled by FFT_BFLY_SAT_CNT_EN.
module fft_bfly_addsub #(
  parameter int DATA_W     = 25,
  parameter int PROD_W     = 44,
  parameter int TW_FRAC    = 17,
  parameter int FIFO_DEPTH = 8,
  parameter int SCALE      = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [2*DATA_W-1:0]   a_i,
  input  logic                  a_valid_i,
  input  logic [2*PROD_W-1:0]   prod_i,
  input  logic                  prod_valid_i,
  output logic [2*DATA_W-1:0]   sum_o,
  output logic [2*DATA_W-1:0]   diff_o,
  output logic                  data_valid_o,
  output logic                  sat_o,
  output logic                  err_o,
  output logic [15:0]           sat_cnt_o
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int P_W = PROD_W - TW_FRAC;
  localparam int S_W = P_W + 1;
  localparam logic signed [S_W:0]    ONE  = 1;
  localparam logic signed [S_W:0]    MAXV = 2**(DATA_W-1) - 1;
  localparam logic signed [S_W:0]    MINV = -(2**(DATA_W-1));
  localparam logic signed [PROD_W:0] HALF = 1 <<< (TW_FRAC-1);

  logic [2*DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr;
  logic empty, full, wr, rd, fifo_err, any_sat, s1_v;
  logic [2*DATA_W-1:0] a_sel;
  logic signed [DATA_W-1:0] a_re, a_im;
  logic signed [PROD_W:0] pr_w, pi_w;
  logic signed [P_W-1:0] p_re, p_im;
  logic signed [S_W-1:0] ar_x, ai_x, pr_x, pi_x;
  logic signed [S_W-1:0] s_re, s_im, d_re, d_im;
  logic [DATA_W:0] q_sr, q_si, q_dr, q_di;

  // Empty FIFO with a simultaneous push bypasses A straight to the datapath.
  assign empty    = wptr == rptr;
  assign full     = (wptr ^ rptr) == {1'b1, {AW{1'b0}}};
  assign wr       = a_valid_i && !(empty && prod_valid_i) && !(full && !prod_valid_i);
  assign rd       = prod_valid_i && !empty;
  assign fifo_err = (a_valid_i && full && !prod_valid_i) || (prod_valid_i && empty && !a_valid_i);
  assign a_sel    = !empty ? mem[rptr[AW-1:0]] : a_valid_i ? a_i : '0;

  always_comb begin
    a_re = a_sel[2*DATA_W-1:DATA_W];
    a_im = a_sel[DATA_W-1:0];
    pr_w = $signed(prod_i[2*PROD_W-1:PROD_W]) + HALF;
    pi_w = $signed(prod_i[PROD_W-1:0]) + HALF;
    p_re = P_W'(pr_w >>> TW_FRAC);
    p_im = P_W'(pi_w >>> TW_FRAC);
    ar_x = a_re;
    ai_x = a_im;
    pr_x = p_re;
    pi_x = p_im;
  end

  function automatic logic [DATA_W:0] rsat(input logic signed [S_W-1:0] x);
    logic signed [S_W:0] xe, r;
    xe = x;
    r  = SCALE != 0 ? (xe + ONE) >>> 1 : xe;
    return r > MAXV ? {1'b1, MAXV[DATA_W-1:0]} : r < MINV ? {1'b1, MINV[DATA_W-1:0]} : {1'b0, r[DATA_W-1:0]};
  endfunction

  always_comb begin
    q_sr    = rsat(s_re);
    q_si    = rsat(s_im);
    q_dr    = rsat(d_re);
    q_di    = rsat(d_im);
    any_sat = s1_v && (q_sr[DATA_W] || q_si[DATA_W] || q_dr[DATA_W] || q_di[DATA_W]);
  end

  always_ff @(posedge clk_i) begin
    if (wr) mem[wptr[AW-1:0]] <= a_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr         <= '0;
      rptr         <= '0;
      s1_v         <= 1'b0;
      s_re         <= '0;
      s_im         <= '0;
      d_re         <= '0;
      d_im         <= '0;
      data_valid_o <= 1'b0;
      sum_o        <= '0;
      diff_o       <= '0;
      sat_o        <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      if (fifo_err) err_o <= 1'b1;
      s1_v <= prod_valid_i;
      if (prod_valid_i) begin
        s_re <= ar_x + pr_x;
        s_im <= ai_x + pi_x;
        d_re <= ar_x - pr_x;
        d_im <= ai_x - pi_x;
      end
      data_valid_o <= s1_v;
      if (s1_v) begin
        sum_o  <= {q_sr[DATA_W-1:0], q_si[DATA_W-1:0]};
        diff_o <= {q_dr[DATA_W-1:0], q_di[DATA_W-1:0]};
      end
      if (any_sat) sat_o <= 1'b1;
    end
  end

`ifdef FFT_BFLY_SAT_CNT_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) sat_cnt_o <= '0;
    else if (any_sat && sat_cnt_o != 16'hFFFF) sat_cnt_o <= sat_cnt_o + 1'b1;
  end
`else
  assign sat_cnt_o = '0;
`endif
endmodule

// File: tb/tb_fft_bfly_addsub.sv
// tb_fft_bfly_addsub: scoreboard bench driving SCALE=0 and SCALE=1 butterflies with identical stimulus.
module tb_fft_bfly_addsub;
  logic clk = 0, reset_i = 1;
  logic [49:0] a_i = '0;
  logic [87:0] prod_i = '0;
  logic a_valid_i = 0, prod_valid_i = 0;
  logic [49:0] sum0, diff0, sum1, diff1;
  logic dv0, dv1, sat0, sat1, err0, err1;
  logic [15:0] cnt0, cnt1;
  int vectors = 0, miscompares = 0;

  typedef struct {logic [1:0][49:0] s; logic [1:0][49:0] d;} exp_t;
  exp_t exq[$];
  logic [49:0] aq[$];
  bit m_err;
  int nsat[2];

  always #5 clk = ~clk;

  fft_bfly_addsub #(.SCALE(0)) u0 (.clk_i(clk), .reset_i(reset_i), .a_i(a_i), .a_valid_i(a_valid_i),
    .prod_i(prod_i), .prod_valid_i(prod_valid_i), .sum_o(sum0), .diff_o(diff0), .data_valid_o(dv0),
    .sat_o(sat0), .err_o(err0), .sat_cnt_o(cnt0));
  fft_bfly_addsub #(.SCALE(1)) u1 (.clk_i(clk), .reset_i(reset_i), .a_i(a_i), .a_valid_i(a_valid_i),
    .prod_i(prod_i), .prod_valid_i(prod_valid_i), .sum_o(sum1), .diff_o(diff1), .data_valid_o(dv1),
    .sat_o(sat1), .err_o(err1), .sat_cnt_o(cnt1));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got %h want %h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [49:0] pa(input longint re, input longint im);
    return {25'(re), 25'(im)};
  endfunction

  function automatic logic [87:0] pp(input longint re, input longint im);
    return {44'(re), 44'(im)};
  endfunction

  function automatic longint clip(input longint v);
    return v > 16777215 ? 16777215 : v < -16777216 ? -16777216 : v;
  endfunction

  function automatic int exp_cnt(input int n);
`ifdef FFT_BFLY_SAT_CNT_EN
    return n > 65535 ? 65535 : n;
`else
    return 0;
`endif
  endfunction

  task automatic model(input bit av, input logic [49:0] a, input bit pv, input logic [87:0] p);
    logic [49:0] au;
    longint ar, ai, pr, pi, r, c;
    longint v[4];
    logic [24:0] o[4];
    bit anysat;
    exp_t e;
    if (pv) begin
      if (aq.size() == 0) begin
        au = av ? a : '0;
        if (!av) m_err = 1;
      end else begin
        au = aq.pop_front();
        if (av) aq.push_back(a);
      end
      ar = longint'($signed(au[49:25]));
      ai = longint'($signed(au[24:0]));
      pr = (longint'($signed(p[87:44])) + 65536) >>> 17;
      pi = (longint'($signed(p[43:0])) + 65536) >>> 17;
      v[0] = ar + pr; v[1] = ai + pi; v[2] = ar - pr; v[3] = ai - pi;
      for (int sc = 0; sc < 2; sc++) begin
        anysat = 0;
        for (int k = 0; k < 4; k++) begin
          r = sc != 0 ? (v[k] + 1) >>> 1 : v[k];
          c = clip(r);
          if (c != r) anysat = 1;
          o[k] = 25'(c);
        end
        e.s[sc] = {o[0], o[1]};
        e.d[sc] = {o[2], o[3]};
        if (anysat) nsat[sc]++;
      end
      exq.push_back(e);
    end else if (av) begin
      if (aq.size() == 8) m_err = 1;
      else aq.push_back(a);
    end
  endtask

  task automatic step(input bit av, input logic [49:0] a, input bit pv, input logic [87:0] p);
    a_valid_i = av; a_i = a; prod_valid_i = pv; prod_i = p;
    model(av, a, pv, p);
    @(posedge clk); #1;
    a_valid_i = 0; prod_valid_i = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, '0, 0, '0);
  endtask

  task automatic do_reset;
    reset_i = 1;
    aq.delete(); exq.delete(); m_err = 0; nsat[0] = 0; nsat[1] = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sum0", sum0, 0); chk("rst_diff0", diff0, 0); chk("rst_dv0", dv0, 0);
    chk("rst_sat0", sat0, 0); chk("rst_err0", err0, 0); chk("rst_cnt0", cnt0, 0);
    chk("rst_sum1", sum1, 0); chk("rst_dv1", dv1, 0); chk("rst_err1", err1, 0);
    reset_i = 0;
  endtask

  task automatic check_flags;
    chk("err0", err0, m_err); chk("err1", err1, m_err);
    chk("sat0", sat0, nsat[0] != 0); chk("sat1", sat1, nsat[1] != 0);
    chk("cnt0", cnt0, exp_cnt(nsat[0])); chk("cnt1", cnt1, exp_cnt(nsat[1]));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset_i && (dv0 || dv1)) begin
      chk("dv_match", dv0, dv1);
      if (exq.size() == 0) chk("spurious_valid", dv0, 0);
      else begin
        e = exq.pop_front();
        chk("sum0", sum0, e.s[0]); chk("diff0", diff0, e.d[0]);
        chk("sum1", sum1, e.s[1]); chk("diff1", diff1, e.d[1]);
      end
    end
  end

  initial begin
    bit av, pv;
    longint pr, pi;
    do_reset();
    // bypass pair, SCALE=1 expectations fixed by hand
    step(1, pa(1000, -200), 1, pp(500 * 131072, 100 * 131072));
    idle(3);
    chk("t1_sum1", sum1, {25'd750, 25'h1FFFFCE});
    chk("t1_diff1", diff1, {25'd250, 25'h1FFFF6A});
    check_flags();
    do_reset();
    for (int i = 1; i <= 3; i++) step(1, pa(i, 0), 0, '0);
    for (int i = 0; i < 3; i++) begin
      step(0, '0, 1, pp(10 * 131072, 0));
      idle(1);
    end
    idle(2);
    chk("t2_sum_re", sum0[49:25], 25'd13);
    chk("t2_diff_re", diff0[49:25], 25'h1FFFFF9);
    check_flags();
    do_reset();
    step(1, pa(16777215, 0), 1, pp(longint'(16777215) * 131072, 0));
    idle(3);
    chk("t3_sum_re", sum0[49:25], 25'd16777215);
    chk("t3_sat0", sat0, 1);
    check_flags();
    do_reset();
    for (int i = 0; i < 9; i++) step(1, pa(100 + i, -i), 0, '0);
    chk("t4_err_ovf", err0, 1);
    for (int i = 0; i < 8; i++) step(0, '0, 1, pp(i * 131072, 0));
    idle(3);
    chk("t4_last_sum_re", sum0[49:25], 25'd114);
    check_flags();
    do_reset();
    step(0, '0, 1, pp(4 * 131072, 0));
    idle(3);
    chk("t5_sum_re", sum0[49:25], 25'd4);
    chk("t5_diff_re", diff0[49:25], 25'h1FFFFFC);
    check_flags();
    do_reset();
    step(1, pa(7, 7), 1, pp(3 * 131072, 3 * 131072));
    step(1, pa(8, 8), 1, pp(3 * 131072, 3 * 131072));
    do_reset();
    for (int i = 0; i < 4; i++) begin
      chk("t6_no_valid", dv0, 0);
      idle(1);
    end
    step(1, pa(-5, 9), 1, pp(-2 * 131072, 65536));
    idle(3);
    check_flags();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      av = $urandom_range(0, 2) != 0;
      pv = $urandom_range(0, 2) != 0;
      if ($urandom_range(0, 3) == 0) begin
        pr = longint'($signed(44'({$urandom, $urandom})));
        pi = longint'($signed(44'({$urandom, $urandom})));
      end else begin
        pr = (longint'($urandom_range(0, 4000)) - 2000) * 131072 + longint'($urandom_range(0, 131071));
        pi = (longint'($urandom_range(0, 4000)) - 2000) * 131072 + longint'($urandom_range(0, 131071));
      end
      step(av, {$urandom, $urandom}, pv, pp(pr, pi));
    end
    idle(4);
    check_flags();
    chk("drain", exq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
